// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the SRAM access controller.
//   state_t   : controller FSM state (IDLE, ACCESS, RESP)
//   req_idx_t : index of one of the two requesters
//   SRAM_ADDR_W / SRAM_DATA_W : default geometry of sram_core
package sram_ctrl_pkg;

  localparam int SRAM_ADDR_W = 10;
  localparam int SRAM_DATA_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef logic req_idx_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   valid      : per-requester request lines
//   advance    : a grant was taken this cycle; move the priority pointer
//   grant      : one-hot grant (all zero when nothing is valid)
//   grant_idx  : index of the granted requester (meaningful when |grant)
module rr_arb2
  import sram_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant,
  output req_idx_t   grant_idx
);

  req_idx_t ptr_q;

  always_comb begin
    grant = 2'b00;
    unique case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  assign grant_idx = grant[1];

  // Pointer always lands on the requester that did not just win, so a lone
  // requester winning still hands the next tie to the other side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else if (advance && (grant != 2'b00)) begin
      ptr_q <= ~grant_idx;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin controller sharing one sram_core between two requesters.
// One access in flight at a time; mem_* is driven only from registers
// latched at the request handshake and held until the core answers or the
// wait times out. A one-cycle response goes back to the owner, and a new
// grant is only made in IDLE while the core's ready is low.
//   req_*_0/1  : valid/ready request channel per requester
//   rsp_*_0/1  : one-cycle response pulse (data, error) to the owner
//   mem_*      : sram_core enable/addr/read_not_write/data/ready
//   busy       : controller not in IDLE
//   last_grant : most recently granted requester
module sram_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W  = SRAM_ADDR_W,
  parameter int DATA_W  = SRAM_DATA_W,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_0,
  output logic              req_ready_0,
  input  logic [ADDR_W-1:0] req_addr_0,
  input  logic              req_rnw_0,
  input  logic [DATA_W-1:0] req_wdata_0,
  input  logic              req_valid_1,
  output logic              req_ready_1,
  input  logic [ADDR_W-1:0] req_addr_1,
  input  logic              req_rnw_1,
  input  logic [DATA_W-1:0] req_wdata_1,
  output logic              rsp_valid_0,
  output logic [DATA_W-1:0] rsp_rdata_0,
  output logic              rsp_err_0,
  output logic              rsp_valid_1,
  output logic [DATA_W-1:0] rsp_rdata_1,
  output logic              rsp_err_1,
  output logic              mem_enable,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rnw,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              last_grant
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // The access gives up in the cycle the counter would reach TIMEOUT, so the
  // response lands TIMEOUT+1 cycles after the handshake edge.
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  state_t            state_q, state_nxt;
  logic              can_grant;
  logic [1:0]        arb_valid;
  logic [1:0]        grant;
  req_idx_t          grant_idx;
  logic              handshake;
  logic              timeout_hit;

  logic [ADDR_W-1:0] addr_q;
  logic              rnw_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  req_idx_t          owner_q;
  logic [CNT_W-1:0]  wait_cnt;

  // Ready is masked by rst_n so nothing appears accepted while in reset.
  assign can_grant = rst_n && (state_q == IDLE) && !mem_ready;
  assign arb_valid = {req_valid_1, req_valid_0} & {2{can_grant}};

  rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (arb_valid),
    .advance   (handshake),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign handshake   = (grant != 2'b00);
  assign req_ready_0 = grant[0];
  assign req_ready_1 = grant[1];

  assign timeout_hit = (TIMEOUT > 0) && (wait_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state_q;
    mem_enable  = 1'b0;
    busy        = 1'b1;
    rsp_valid_0 = 1'b0;
    rsp_rdata_0 = '0;
    rsp_err_0   = 1'b0;
    rsp_valid_1 = 1'b0;
    rsp_rdata_1 = '0;
    rsp_err_1   = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (handshake) state_nxt = ACCESS;
      end
      ACCESS: begin
        mem_enable = 1'b1;
        // A ready seen in the final waiting cycle still counts as success.
        if (mem_ready || timeout_hit) state_nxt = RESP;
      end
      RESP: begin
        if (owner_q) begin
          rsp_valid_1 = 1'b1;
          rsp_rdata_1 = rdata_q;
          rsp_err_1   = err_q;
        end else begin
          rsp_valid_0 = 1'b1;
          rsp_rdata_0 = rdata_q;
          rsp_err_0   = err_q;
        end
        state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Request fields and response data; reset clears them so every output is
  // zero while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      rnw_q   <= 1'b0;
      wdata_q <= '0;
      owner_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (handshake) begin
        addr_q  <= grant_idx ? req_addr_1  : req_addr_0;
        rnw_q   <= grant_idx ? req_rnw_1   : req_rnw_0;
        wdata_q <= grant_idx ? req_wdata_1 : req_wdata_0;
        owner_q <= grant_idx;
      end
      if ((state_q == ACCESS) && (state_nxt == RESP)) begin
        err_q   <= !mem_ready;
        rdata_q <= (mem_ready && rnw_q) ? mem_rdata : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (handshake) begin
      wait_cnt <= '0;
    end else if ((state_q == ACCESS) && (wait_cnt != {CNT_W{1'b1}})) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign mem_addr   = addr_q;
  assign mem_rnw    = rnw_q;
  assign mem_wdata  = wdata_q;
  assign last_grant = owner_q;

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

  localparam int AW = 10;
  localparam int DW = 4;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid_0 = 1'b0, req_valid_1 = 1'b0;
  logic          req_ready_0, req_ready_1;
  logic [AW-1:0] req_addr_0 = '0, req_addr_1 = '0;
  logic          req_rnw_0 = 1'b0, req_rnw_1 = 1'b0;
  logic [DW-1:0] req_wdata_0 = '0, req_wdata_1 = '0;
  logic          rsp_valid_0, rsp_valid_1;
  logic [DW-1:0] rsp_rdata_0, rsp_rdata_1;
  logic          rsp_err_0, rsp_err_1;
  logic          mem_enable;
  logic [AW-1:0] mem_addr;
  logic          mem_rnw;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          busy, last_grant;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_addr_0(req_addr_0),
    .req_rnw_0(req_rnw_0), .req_wdata_0(req_wdata_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_addr_1(req_addr_1),
    .req_rnw_1(req_rnw_1), .req_wdata_1(req_wdata_1),
    .rsp_valid_0(rsp_valid_0), .rsp_rdata_0(rsp_rdata_0), .rsp_err_0(rsp_err_0),
    .rsp_valid_1(rsp_valid_1), .rsp_rdata_1(rsp_rdata_1), .rsp_err_1(rsp_err_1),
    .mem_enable(mem_enable), .mem_addr(mem_addr), .mem_rnw(mem_rnw),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .last_grant(last_grant)
  );

  always #5 clk = ~clk;

  // Behavioural sram_core: ready rises in the lat-th enable cycle, optional
  // sticky ready after completion, or never (hang).
  logic          model_ready = 1'b0;
  logic          force_ready = 1'b0;
  logic [DW-1:0] mem_arr [0:1023];
  int            lat = 3;
  bit            hang = 1'b0;
  int            sticky = 0;
  int            en_cnt = 0;
  int            stick_cnt = 0;

  assign mem_ready = model_ready | force_ready;
  assign mem_rdata = mem_arr[mem_addr];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 1024; i++) mem_arr[i] <= '0;
      mem_arr[10'h155] <= 4'hA;
      model_ready <= 1'b0;
      en_cnt      <= 0;
      stick_cnt   <= 0;
    end else if (mem_enable && mem_ready) begin
      if (!mem_rnw) mem_arr[mem_addr] <= mem_wdata;
      en_cnt <= 0;
      if (sticky > 0) stick_cnt <= sticky;
      else            model_ready <= 1'b0;
    end else if (mem_enable) begin
      if (!hang && (en_cnt + 1 == lat - 1)) model_ready <= 1'b1;
      en_cnt <= en_cnt + 1;
    end else begin
      en_cnt <= 0;
      if (stick_cnt > 0) begin
        stick_cnt <= stick_cnt - 1;
        if (stick_cnt == 1) model_ready <= 1'b0;
      end
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Bus monitor: fields stable during ACCESS, grant order, enable-low gaps.
  logic            en_prev = 1'b0;
  logic [AW+DW:0]  fld_prev = '0;
  bit              mon_on = 1'b0;
  bit              first_acc = 1'b1;
  int              low_cnt = 0;
  int              gq[$];

  always @(negedge clk) begin
    if (mem_enable && en_prev)
      check("field_hold", 32'({mem_addr, mem_rnw, mem_wdata}), 32'(fld_prev));
    if (mem_enable && !en_prev && mon_on) begin
      gq.push_back(int'(last_grant));
      if (!first_acc) check("enable_gap", 32'(low_cnt >= 1), 32'd1);
      first_acc = 1'b0;
    end
    low_cnt  = mem_enable ? 0 : low_cnt + 1;
    fld_prev = {mem_addr, mem_rnw, mem_wdata};
    en_prev  = mem_enable;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic v, input logic [AW-1:0] a,
                         input logic rnw, input logic [DW-1:0] wd);
    if (idx == 0) begin
      req_valid_0 = v; req_addr_0 = a; req_rnw_0 = rnw; req_wdata_0 = wd;
    end else begin
      req_valid_1 = v; req_addr_1 = a; req_rnw_1 = rnw; req_wdata_1 = wd;
    end
  endtask

  function automatic logic rdy(input int idx);
    return (idx == 0) ? req_ready_0 : req_ready_1;
  endfunction

  function automatic logic rv(input int idx);
    return (idx == 0) ? rsp_valid_0 : rsp_valid_1;
  endfunction

  // Called at posedge+1; returns at posedge+1 of the first ACCESS cycle.
  task automatic issue(input int idx, input logic [AW-1:0] a, input logic rnw,
                       input logic [DW-1:0] wd);
    bit ok;
    ok = 1'b0;
    set_req(idx, 1'b1, a, rnw, wd);
    for (int c = 0; c < 200 && !ok; c++) begin
      #1;
      if (rdy(idx)) ok = 1'b1;
      tick();
    end
    set_req(idx, 1'b0, a, rnw, wd);
    check($sformatf("grant_req%0d", idx), 32'(ok), 32'd1);
  endtask

  // Runs until rsp_valid_<idx> is high in the current cycle, counting the
  // enable-high cycles seen on the way.
  task automatic wait_rsp(input int idx, output int en_cycles);
    bit got;
    got = 1'b0;
    en_cycles = 0;
    for (int c = 0; c < 100 && !got; c++) begin
      if (rv(idx)) got = 1'b1;
      else begin
        if (mem_enable) en_cycles++;
        tick();
      end
    end
    check($sformatf("rsp_seen_%0d", idx), 32'(got), 32'd1);
    check($sformatf("rsp_other_quiet_%0d", idx), 32'(rv(1 - idx)), 32'd0);
  endtask

  typedef struct {
    logic v0;
    logic v1;
    logic mr;
    logic er0;
    logic er1;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int   en;
    bit   seen;

    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_enable", 32'(mem_enable), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_last_grant", 32'(last_grant), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_rsp", 32'({rsp_valid_0, rsp_valid_1, rsp_err_0, rsp_err_1}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Combinational ready / tie-break with the pointer at requester 0
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req_valid_0 = tbl[i].v0;
      req_valid_1 = tbl[i].v1;
      force_ready = tbl[i].mr;
      #1;
      check($sformatf("vec%0d_ready0", i), 32'(req_ready_0), 32'(tbl[i].er0));
      check($sformatf("vec%0d_ready1", i), 32'(req_ready_1), 32'(tbl[i].er1));
      #1;
      req_valid_0 = 1'b0;
      req_valid_1 = 1'b0;
      force_ready = 1'b0;
    end
    tick();

    // Contention: both requesters keep issuing, 4 writes each
    mon_on = 1'b1;
    fork
      begin
        for (int k = 0; k < 4; k++) issue(0, AW'(10'h100 + k), 1'b0, DW'(k));
      end
      begin
        for (int k = 0; k < 4; k++) issue(1, AW'(10'h200 + k), 1'b0, DW'(k + 8));
      end
    join
    repeat (6) tick();
    mon_on = 1'b0;
    check("contention_count", 32'(gq.size()), 32'd8);
    for (int i = 0; i < gq.size(); i++)
      check($sformatf("contention_grant%0d", i), 32'(gq[i]), 32'(i % 2));

    // Single read by requester 0
    set_req(0, 1'b1, 10'h155, 1'b1, 4'h0);
    #1;
    check("read_ready0", 32'(req_ready_0), 32'd1);
    check("read_ready1", 32'(req_ready_1), 32'd0);
    tick();
    set_req(0, 1'b0, 10'h155, 1'b1, 4'h0);
    check("read_mem_addr", 32'(mem_addr), 32'h155);
    check("read_mem_rnw", 32'(mem_rnw), 32'd1);
    wait_rsp(0, en);
    check("read_enable_cycles", 32'(en), 32'd3);
    check("read_rdata", 32'(rsp_rdata_0), 32'hA);
    check("read_err", 32'(rsp_err_0), 32'd0);
    check("read_resp_enable", 32'(mem_enable), 32'd0);
    tick();
    check("read_pulse_end", 32'(rsp_valid_0), 32'd0);
    check("read_idle", 32'(busy), 32'd0);

    // Requester 1 writes, requester 0 reads it back (pointer now at 1)
    set_req(1, 1'b1, 10'h2FF, 1'b0, 4'h3);
    #1;
    check("wr_ready1", 32'(req_ready_1), 32'd1);
    tick();
    set_req(1, 1'b0, 10'h2FF, 1'b0, 4'h3);
    check("wr_mem_fields", 32'({mem_addr, mem_rnw, mem_wdata}), 32'({10'h2FF, 1'b0, 4'h3}));
    set_req(0, 1'b1, 10'h2FF, 1'b1, 4'h0);
    #1;
    check("wr_busy_ready0", 32'(req_ready_0), 32'd0);
    wait_rsp(1, en);
    check("wr_rdata_zero", 32'(rsp_rdata_1), 32'd0);
    check("wr_err", 32'(rsp_err_1), 32'd0);
    tick();
    check("rb_ready0", 32'(req_ready_0), 32'd1);
    tick();
    set_req(0, 1'b0, 10'h2FF, 1'b1, 4'h0);
    wait_rsp(0, en);
    check("rb_rdata", 32'(rsp_rdata_0), 32'h3);

    // Timeout: core never answers
    tick();
    hang = 1'b1;
    issue(0, 10'h001, 1'b1, 4'h0);
    wait_rsp(0, en);
    check("to_enable_cycles", 32'(en), 32'(TO));
    check("to_err", 32'(rsp_err_0), 32'd1);
    check("to_rdata", 32'(rsp_rdata_0), 32'd0);
    check("to_enable_low", 32'(mem_enable), 32'd0);
    hang = 1'b0;
    tick();
    force_ready = 1'b1;
    set_req(1, 1'b1, 10'h002, 1'b1, 4'h0);
    #1;
    check("to_ready_held_a", 32'(req_ready_1), 32'd0);
    tick();
    check("to_ready_held_b", 32'(req_ready_1), 32'd0);
    force_ready = 1'b0;
    #1;
    check("to_ready_after", 32'(req_ready_1), 32'd1);
    tick();
    set_req(1, 1'b0, 10'h002, 1'b1, 4'h0);
    wait_rsp(1, en);
    tick();

    // Sticky ready: stays high 3 cycles after the access
    sticky = 3;
    issue(1, 10'h2FF, 1'b1, 4'h0);
    wait_rsp(1, en);
    check("sticky_rdata", 32'(rsp_rdata_1), 32'h3);
    sticky = 0;
    set_req(0, 1'b1, 10'h155, 1'b1, 4'h0);
    for (int s = 0; s < 3; s++) begin
      #1;
      check($sformatf("sticky_stall%0d", s), 32'(req_ready_0), 32'd0);
      tick();
    end
    #1;
    check("sticky_release", 32'(req_ready_0), 32'd1);
    tick();
    set_req(0, 1'b0, 10'h155, 1'b1, 4'h0);
    wait_rsp(0, en);
    check("sticky_next_rdata", 32'(rsp_rdata_0), 32'hA);
    tick();

    // Asynchronous reset in the middle of an access
    lat = 8;
    issue(0, 10'h155, 1'b1, 4'h0);
    tick();
    check("mid_enable_before", 32'(mem_enable), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_enable", 32'(mem_enable), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
    check("mid_rst_mem_rnw", 32'(mem_rnw), 32'd0);
    check("mid_rst_rsp", 32'({rsp_valid_0, rsp_valid_1, rsp_rdata_0, rsp_rdata_1}), 32'd0);
    check("mid_rst_last_grant", 32'(last_grant), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    lat = 3;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (rsp_valid_0 || rsp_valid_1) seen = 1'b1;
    end
    check("mid_no_response", 32'(seen), 32'd0);
    issue(1, 10'h2FF, 1'b1, 4'h0);
    check("post_rst_grant1", 32'(last_grant), 32'd1);
    wait_rsp(1, en);
    tick();
    req_valid_0 = 1'b1;
    req_valid_1 = 1'b1;
    #1;
    check("post_rst_tie0", 32'(req_ready_0), 32'd1);
    check("post_rst_tie1", 32'(req_ready_1), 32'd0);
    #1;
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
